std_fifo_param: RTL
===================

Name: std_fifo_param

Overview:
- Parametrised synchronous FIFO. Successor to the fixed 8-bit x 64-entry std_fifo.
- Adds configurable width and depth, an occupancy count, and programmable almost-full/almost-empty thresholds.
- Single clock domain.
- General-purpose buffer between pipeline stages in the accelerator datapath: message queues, label streams.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 64, number of entries; power of two, >=2.
- AF_MARGIN, 4, almost_full asserts when count >= DEPTH-AF_MARGIN; range 0..DEPTH-1.
- AE_MARGIN, 4, almost_empty asserts when count <= AE_MARGIN; range 0..DEPTH-1.
- CW, $clog2(DEPTH+1), count width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- push  in  1  write request.
- pop  in  1  read request.
- d  in  WIDTH  write data, sampled on the edge where push is accepted.
- q  out  WIDTH  read data; registered.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- almost_empty  out  1  count <= AE_MARGIN.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; present only with STD_FIFO_ERR_EN.
- underflow  out  1  sticky; present only with STD_FIFO_ERR_EN.

Behaviour:
- Reset: one clock, one reset. Reset is synchronous, active-high, named rst; the clock is clk.
- Reset values: rd_ptr=wr_ptr=0, count=0, q=0, empty=1, full=0, almost_empty=1, almost_full=(AF_MARGIN>=DEPTH ? 1 : 0) (effectively 0 for legal values), overflow=underflow=0.
- Reset mid-operation: contents are discarded. Storage RAM is not cleared; only pointers, count and q reset.
- Acceptance: push_ok = push & ~full; pop_ok = pop & ~empty. Both are evaluated against the current registered flags.
- Write: on push_ok, mem[wr_ptr] <= d and wr_ptr <= wr_ptr+1. The pointer is log2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
- Read: on pop_ok, q <= mem[rd_ptr] and rd_ptr <= rd_ptr+1 (wraps). Data is valid in the cycle after the pop edge. q holds its value when no pop is accepted.
- Count update:
  - push_ok & ~pop_ok: +1.
  - pop_ok & ~push_ok: -1.
  - both or neither: unchanged.
- Flags: full, empty, almost_full and almost_empty are registered and computed from next-count, so they are valid the same cycle count changes.
- Full boundary: push while full is dropped and count is unchanged. Push+pop while full: only the pop is accepted, count goes to DEPTH-1, and d is lost.
- Empty boundary: pop while empty is ignored; q holds and count stays 0. Push+pop while empty: only the push is accepted, count goes to 1, and q is unchanged.
- Simultaneous push+pop at 0<count<DEPTH: both accepted, count unchanged, pointers both advance.
- Ordering: strict FIFO order. Words pushed in the same cycle a pop reads never bypass; they are read from RAM in a later cycle.
- Latency: a word pushed on edge N may be popped on edge N+1 at the earliest. It appears on q after edge N+1.
- Storage: inferred as RAM, mem[DEPTH] x WIDTH. No reset on the array.

Optional Feature:
- Macro: STD_FIFO_ERR_EN.
- When defined:
  - overflow ports exist; overflow sets on any edge with push & full.
  - underflow ports exist; underflow sets on any edge with pop & empty.
  - Both are sticky until rst and read 0 after reset.
  - A dropped access still has no other effect.
- When undefined: overflow and underflow ports and logic are absent. Dropped accesses are silent. All other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=64, AF_MARGIN=4, AE_MARGIN=4):
- Reset: hold rst 10 cycles, release -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, q=0.
- Fill: push d=1..64 on consecutive cycles. Expect:
  - empty=0 after first edge.
  - almost_empty deasserts when count=5.
  - almost_full asserts at count=60.
  - full=1 after the 64th edge.
  - 65th push (d=65) is dropped and count stays 64. With STD_FIFO_ERR_EN, overflow=1.
- Drain: pop 64 cycles -> q=1..64 in order, each one cycle after its pop edge. Then empty=1, count=0. Extra pop leaves q=64. With STD_FIFO_ERR_EN, underflow=1.
- Simultaneous: at count=10, push+pop for 100 cycles with incrementing d -> count stays 10, q sequence is continuous, pointers wrap past 63 without data loss.
- Edge collisions:
  - Push+pop at count=0 -> count=1, q unchanged.
  - Push+pop at count=64 -> count=63, the pushed word is absent from the later drain.
- Mid-operation reset: at count=37 assert rst for 1 cycle -> count=0, empty=1, q=0, sticky errors cleared. A following push 0xA5 then pop yields q=0xA5.

Source files
------------

// File: rtl/std_fifo_param_if.sv
// std_fifo_param_if: handshake/data bundle for std_fifo_param.
//
// Signals:
//   push, pop          write / read requests (driven by the user side)
//   d                  write data
//   q                  registered read data
//   full, empty        occupancy flags
//   almost_full/empty  threshold flags
//   count              occupancy, 0..DEPTH
//   overflow/underflow sticky error flags, only when STD_FIFO_ERR_EN is defined
//
// Modports: master = user side (drives push/pop/d), slave = the FIFO itself.
interface std_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef STD_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, d,
    input  q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, d,
    output q, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
`else
  modport master (
    output push, pop, d,
    input  q, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  push, pop, d,
    output q, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/std_fifo_param.sv
// std_fifo_param: parametrised single-clock synchronous FIFO with occupancy count and
// programmable almost-full / almost-empty thresholds.
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset (pointers, count, q, flags; the RAM is not cleared)
//   bus  std_fifo_param_if.slave: push/pop/d in; q/full/empty/almost_full/almost_empty/count out
//
// Parameters: WIDTH (word bits), DEPTH (entries, power of two >= 2),
//   AF_MARGIN (almost_full when count >= DEPTH-AF_MARGIN),
//   AE_MARGIN (almost_empty when count <= AE_MARGIN).
//
// Optional feature macro: STD_FIFO_ERR_EN adds sticky overflow/underflow flags on the
// interface. Without it dropped accesses are silent.
module std_fifo_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned AE_MARGIN = 4
) (
  input logic                  clk,
  input logic                  rst,
  std_fifo_param_if.slave      bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  // Guarded so an out-of-range margin cannot wrap the unsigned threshold.
  localparam int unsigned AfThr = (AF_MARGIN >= DEPTH) ? 0 : (DEPTH - AF_MARGIN);
  localparam logic        AfRst = (AF_MARGIN >= DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;

  logic             push_ok;
  logic             pop_ok;

  // Acceptance uses the registered flags only, so a pop never frees a slot for a push
  // in the same cycle when full (and vice versa when empty).
  assign push_ok = bus.push & ~full_q;
  assign pop_ok  = bus.pop & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_d      = q_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      // Reads the RAM before this edge's write lands, so a same-cycle push never bypasses.
      q_d      = mem_q[rd_ptr_q];
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from next-count so they change on the same edge as count.
  always_comb begin
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (32'(count_d) >= AfThr);
    ae_d    = (32'(count_d) <= AE_MARGIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= AfRst;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Storage array: no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q] <= bus.d;
    end
  end

  assign bus.q            = q_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;

`ifdef STD_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky: any rejected request sets the flag until the next reset.
  always_comb begin
    ovf_d = ovf_q | (bus.push & full_q);
    udf_d = udf_q | (bus.pop & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif

endmodule
